// File: rtl/lsb_embed_pkg.sv
// Shared constants and state encoding for the LSB steganography embedder.
package lsb_embed_pkg;

  // Bit buffer depth: up to 2 leftover bits plus one 32-bit word
  localparam int unsigned BUF_W  = 34;
  // Message bits carried per pixel (one LSB in each of R, G, B)
  localparam int unsigned BPP    = 3;
  // buf_cnt range 0..34
  localparam int unsigned CNT_W  = 6;
  // Bits consumed per pixel range 0..3
  localparam int unsigned NEED_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/lsb_embed_bitbuf.sv
// MSB-aligned message bit buffer: shift out consumed bits, append loaded words.
module lsb_bitbuf
  import lsb_embed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [NEED_W-1:0]     consume_n,
  output logic [BPP-1:0]        head,
  output logic [CNT_W-1:0]      cnt
);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic [BUF_W-1:0] word_al;
  logic [CNT_W-1:0] cnt_after;
  logic [CNT_W-1:0] cnt_d;

  assign head = buf_q[BUF_W-1 -: BPP];

  // Consume first, then place the new word right after the surviving bits
  always_comb begin
    cnt_after = cnt - CNT_W'(consume_n);
    word_al   = BUF_W'(load_data) << (BUF_W - DATA_WIDTH);
    buf_d     = buf_q << consume_n;
    cnt_d     = cnt_after;
    if (load) begin
      buf_d = buf_d | (word_al >> cnt_after);
      cnt_d = cnt_after + CNT_W'(DATA_WIDTH);
    end
  end

  // Buffer state; cleared on reset and at frame start
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      buf_q <= '0;
      cnt   <= '0;
    end else begin
      buf_q <= buf_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/lsb_embed.sv
// Embeds a message bit stream into the LSBs of R/G/B cover pixels.
module lsb_embed
  import lsb_embed_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   msg_len,
  input  logic [LEN_WIDTH-1:0]   frame_pixels,
  input  logic [DATA_WIDTH-1:0]  msg_data,
  input  logic                   msg_vld,
  output logic                   msg_rdy,
  input  logic [PIXEL_WIDTH-1:0] pix_r,
  input  logic [PIXEL_WIDTH-1:0] pix_g,
  input  logic [PIXEL_WIDTH-1:0] pix_b,
  input  logic                   pix_vld,
  output logic                   pix_rdy,
  output logic [PIXEL_WIDTH-1:0] out_r,
  output logic [PIXEL_WIDTH-1:0] out_g,
  output logic [PIXEL_WIDTH-1:0] out_b,
  output logic                   out_req,
  input  logic                   out_vld,
  output logic                   busy,
  output logic                   done,
  output logic                   trunc
);

  localparam int unsigned CAP_W = LEN_WIDTH + 2;
  localparam int unsigned WRD_W = LEN_WIDTH + 1;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   bits_left;
  logic [LEN_WIDTH-1:0]   words_left;
  logic [LEN_WIDTH-1:0]   pix_left;
  logic [NEED_W-1:0]      need;
  logic [NEED_W-1:0]      consume_n;
  logic [BPP-1:0]         head;
  logic [CNT_W-1:0]       buf_cnt;
  logic                   run;
  logic                   msg_xfer;
  logic                   pix_xfer;
  logic                   buf_clr;
  logic [CAP_W-1:0]       cap;
  logic                   over;
  logic [LEN_WIDTH-1:0]   eff_bits;
  logic [LEN_WIDTH-1:0]   eff_words;
  logic [PIXEL_WIDTH-1:0] emb_r;
  logic [PIXEL_WIDTH-1:0] emb_g;
  logic [PIXEL_WIDTH-1:0] emb_b;

  // Handshakes and per-pixel bit demand
  assign run       = (state == S_RUN);
  assign need      = (bits_left >= LEN_WIDTH'(BPP)) ? NEED_W'(BPP) : bits_left[NEED_W-1:0];
  assign msg_rdy   = run && (buf_cnt < CNT_W'(BPP)) && (words_left != '0);
  assign pix_rdy   = run && (!out_req || out_vld) && (buf_cnt >= CNT_W'(need));
  assign msg_xfer  = msg_vld && msg_rdy;
  assign pix_xfer  = pix_vld && pix_rdy;
  assign consume_n = pix_xfer ? need : '0;
  assign buf_clr   = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);

  // Frame capacity; excess message bits are never requested
  assign cap       = CAP_W'(frame_pixels) + (CAP_W'(frame_pixels) << 1);
  assign over      = CAP_W'(msg_len) > cap;
  assign eff_bits  = over ? cap[LEN_WIDTH-1:0] : msg_len;
  assign eff_words = LEN_WIDTH'((WRD_W'(eff_bits) + WRD_W'(DATA_WIDTH - 1)) / WRD_W'(DATA_WIDTH));

  lsb_bitbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bitbuf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .load      (msg_xfer),
    .load_data (msg_data),
    .consume_n (consume_n),
    .head      (head),
    .cnt       (buf_cnt)
  );

  // Replace LSBs of R, G, B in order with the next buffered bits
  always_comb begin
    emb_r = pix_r;
    emb_g = pix_g;
    emb_b = pix_b;
    if (need >= NEED_W'(1)) emb_r[0] = head[2];
    if (need >= NEED_W'(2)) emb_g[0] = head[1];
    if (need == NEED_W'(3)) emb_b[0] = head[0];
  end

  // FSM, counters and output pixel register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      bits_left  <= '0;
      words_left <= '0;
      pix_left   <= '0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_req    <= 1'b0;
      done       <= 1'b0;
      trunc      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_req && out_vld) out_req <= 1'b0;
      if (pix_xfer) begin
        out_r     <= emb_r;
        out_g     <= emb_g;
        out_b     <= emb_b;
        out_req   <= 1'b1;
        bits_left <= bits_left - LEN_WIDTH'(need);
        pix_left  <= pix_left - LEN_WIDTH'(1);
      end
      if (msg_xfer) words_left <= words_left - LEN_WIDTH'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            trunc      <= over;
            bits_left  <= eff_bits;
            words_left <= eff_words;
            pix_left   <= frame_pixels;
            state      <= (frame_pixels == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (pix_xfer && (pix_left == LEN_WIDTH'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!out_req || out_vld) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_embed.sv
// Directed bench for lsb_embed with a pixel scoreboard and bit-level model.
module tb_lsb_embed;

  localparam int unsigned PW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] msg_len = '0;
  logic [LW-1:0] frame_pixels = '0;
  logic [DW-1:0] msg_data = '0;
  logic          msg_vld = 1'b0;
  logic          msg_rdy;
  logic [PW-1:0] pix_r = '0;
  logic [PW-1:0] pix_g = '0;
  logic [PW-1:0] pix_b = '0;
  logic          pix_vld = 1'b0;
  logic          pix_rdy;
  logic [PW-1:0] out_r;
  logic [PW-1:0] out_g;
  logic [PW-1:0] out_b;
  logic          out_req;
  logic          out_vld = 1'b1;
  logic          busy;
  logic          done;
  logic          trunc;

  always #5 clk = ~clk;

  lsb_embed #(
    .PIXEL_WIDTH (PW),
    .DATA_WIDTH  (DW),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msg_len      (msg_len),
    .frame_pixels (frame_pixels),
    .msg_data     (msg_data),
    .msg_vld      (msg_vld),
    .msg_rdy      (msg_rdy),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .pix_vld      (pix_vld),
    .pix_rdy      (pix_rdy),
    .out_r        (out_r),
    .out_g        (out_g),
    .out_b        (out_b),
    .out_req      (out_req),
    .out_vld      (out_vld),
    .busy         (busy),
    .done         (done),
    .trunc        (trunc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0]   msg_words [4];
  logic [3*PW-1:0] exp_q [$];
  logic [3*PW-1:0] got_q [$];
  int              first_acc;
  int              done_cyc;
  int              word1_at_pix;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic msg_bit(input int k);
    logic [DW-1:0] w;
    w = msg_words[k / DW];
    return w[DW - 1 - (k % DW)];
  endfunction

  // Reference embedding: message bits idx.. go to R, G, B LSBs while below eff
  function automatic logic [3*PW-1:0] model_pix(input logic [3*PW-1:0] p, input int idx, input int eff);
    logic [3*PW-1:0] q;
    q = p;
    for (int c = 0; c < 3; c++)
      if (idx + c < eff) q[2*PW - PW*c] = msg_bit(idx + c);
    return q;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},     64'({out_r, out_g, out_b}), 64'(0));
    check({tag, "_out_req"}, 64'(out_req), 64'(0));
    check({tag, "_msg_rdy"}, 64'(msg_rdy), 64'(0));
    check({tag, "_pix_rdy"}, 64'(pix_rdy), 64'(0));
    check({tag, "_busy"},    64'(busy),    64'(0));
    check({tag, "_done"},    64'(done),    64'(0));
    check({tag, "_trunc"},   64'(trunc),   64'(0));
  endtask

  task automatic run_frame(input string name, input int mlen, input int fp,
                           input bit rand_pix, input int bp_at, input int rst_at);
    int eff, exp_words, word_i, pix_i, bit_idx, bp_cnt, last_acc, n;
    bit done_seen, aborted, prev_acc, in_bp;
    logic [3*PW-1:0] cur_pix, held, expv, gotv;

    eff       = (mlen > 3*fp) ? 3*fp : mlen;
    exp_words = (eff + DW - 1) / DW;
    word_i = 0; pix_i = 0; bit_idx = 0; bp_cnt = 0; last_acc = 0;
    done_seen = 0; aborted = 0; prev_acc = 0; held = '0;
    first_acc = -1; done_cyc = -1; word1_at_pix = -1;
    exp_q.delete();
    got_q.delete();
    cur_pix = rand_pix ? (3*PW)'($urandom) : '1;

    @(negedge clk);
    check({name, "_idle_busy"}, 64'(busy), 64'(0));
    msg_len = LW'(mlen);
    frame_pixels = LW'(fp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_trunc"}, 64'(trunc), 64'(mlen > 3*fp));
    check({name, "_busy"},  64'(busy),  64'(1));

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        break;
      end
      if (rst_at >= 0 && pix_i == rst_at) begin
        rst = 1'b0;
        msg_vld = 1'b0;
        pix_vld = 1'b0;
        @(negedge clk);
        check_all_zero({name, "_rst"});
        rst = 1'b1;
        aborted = 1;
        break;
      end
      // A start pulse while busy must be ignored
      start = (cyc == 3);
      if (cyc == 3) begin
        msg_len = '1;
        frame_pixels = LW'(1);
      end
      msg_vld = (word_i < 4);
      msg_data = (word_i < 4) ? msg_words[word_i] : '0;
      pix_vld = (pix_i < fp);
      {pix_r, pix_g, pix_b} = cur_pix;
      in_bp = (bp_at >= 0) && (pix_i >= bp_at) && (bp_cnt < 5);
      if (in_bp) bp_cnt++;
      out_vld = !in_bp;
      #1;
      if (prev_acc) check({name, "_latency"}, 64'(out_req), 64'(1));
      if (in_bp) begin
        check({name, "_bp_pix_rdy"}, 64'(pix_rdy), 64'(0));
        check({name, "_bp_out_req"}, 64'(out_req), 64'(1));
        if (bp_cnt == 1) held = {out_r, out_g, out_b};
        else check({name, "_bp_hold"}, 64'({out_r, out_g, out_b}), 64'(held));
      end
      if (msg_vld && msg_rdy) begin
        if (word_i == 1) word1_at_pix = pix_i;
        word_i++;
      end
      if (out_req && out_vld) begin
        gotv = {out_r, out_g, out_b};
        got_q.push_back(gotv);
        n = exp_q.size();
        check({name, "_sb_nonempty"}, 64'(n > 0), 64'(1));
        if (n > 0) begin
          expv = exp_q.pop_front();
          check({name, "_pixel"}, 64'(gotv), 64'(expv));
        end
      end
      prev_acc = pix_vld && pix_rdy;
      if (prev_acc) begin
        exp_q.push_back(model_pix(cur_pix, bit_idx, eff));
        bit_idx += ((eff - bit_idx) > 3) ? 3 : (eff - bit_idx);
        if (pix_i == 0) first_acc = cyc;
        last_acc = cyc;
        pix_i++;
        cur_pix = rand_pix ? (3*PW)'($urandom) : '1;
      end
      @(negedge clk);
      start = 1'b0;
    end

    if (!aborted) begin
      check({name, "_done_seen"}, 64'(done_seen), 64'(1));
      check({name, "_pix_count"}, 64'(pix_i), 64'(fp));
      check({name, "_words"},     64'(word_i), 64'(exp_words));
      check({name, "_bits"},      64'(bit_idx), 64'(eff));
      check({name, "_sb_drained"}, 64'(exp_q.size()), 64'(0));
      if (fp > 0) check({name, "_done_lat"}, 64'(done_cyc - last_acc), 64'(2));
      check({name, "_idle"},     64'(busy), 64'(0));
      check({name, "_trunc_held"}, 64'(trunc), 64'(mlen > 3*fp));
      @(negedge clk);
      check({name, "_done_pulse"}, 64'(done), 64'(0));
    end
    msg_vld = 1'b0;
    pix_vld = 1'b0;
    out_vld = 1'b1;
  endtask

  initial begin
    logic [3*PW-1:0] g;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Basic embed: 6 bits 101010 over two white pixels
    msg_words[0] = 32'hA800_0000;
    msg_words[1] = '0; msg_words[2] = '0; msg_words[3] = '0;
    run_frame("basic", 6, 2, 0, -1, -1);
    g = (got_q.size() > 0) ? got_q[0] : '0;
    check("basic_px0", 64'(g), 64'(24'hFFFEFF));
    g = (got_q.size() > 1) ? got_q[1] : '0;
    check("basic_px1", 64'(g), 64'(24'hFEFFFE));
    check("basic_done_cycle", 64'(done_cyc - first_acc), 64'(3));

    // Word straddle: second word requested once only 2 bits remain
    for (int i = 0; i < 4; i++) msg_words[i] = $urandom;
    run_frame("straddle", 64, 22, 1, -1, -1);
    check("straddle_word1_at", 64'(word1_at_pix), 64'(10));

    // Backpressure mid-frame
    for (int i = 0; i < 4; i++) msg_words[i] = $urandom;
    run_frame("backpressure", 40, 16, 1, 5, -1);

    // Truncation: 10 bits into 3 pixels
    for (int i = 0; i < 4; i++) msg_words[i] = $urandom;
    run_frame("trunc", 10, 3, 1, -1, -1);

    // Tail pass-through: 4 zero bits into white pixels
    for (int i = 0; i < 4; i++) msg_words[i] = '0;
    run_frame("tail", 4, 3, 0, -1, -1);
    g = (got_q.size() > 0) ? got_q[0] : '0;
    check("tail_px0", 64'(g), 64'(24'hFEFEFE));
    g = (got_q.size() > 1) ? got_q[1] : '0;
    check("tail_px1", 64'(g), 64'(24'hFEFFFF));
    g = (got_q.size() > 2) ? got_q[2] : '0;
    check("tail_px2", 64'(g), 64'(24'hFFFFFF));

    // Zero-pixel frame completes immediately
    run_frame("empty", 5, 0, 1, -1, -1);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) msg_words[i] = $urandom;
    run_frame("abort", 24, 8, 1, -1, 5);
    @(negedge clk);
    check_all_zero("post_abort");
    for (int i = 0; i < 4; i++) msg_words[i] = $urandom;
    run_frame("clean", 24, 8, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
